// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Data-memory port between the access unit and a ready-handshake memory.
//   mem_req    : access unit requests a transfer
//   mem_we     : 1 = store, 0 = load
//   mem_addr   : word-aligned byte address
//   mem_be     : byte enables, one per byte lane
//   mem_wdata  : lane-replicated store data
//   mem_rdata  : read word returned by memory
//   mem_ready  : memory completes the request this cycle
// master = access unit side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_access_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Load/store controller between the execute stage and a ready-handshake data
// memory. Builds byte enables and replicated store data for sub-word stores,
// aligns and extends load data into ReadMem, and reports misaligned, illegal
// and timed-out accesses through Error alongside the one-cycle Done pulse.
//   clk, rst           : clock, asynchronous active-high reset
//   start              : request strobe, sampled only while idle
//   MemRead, MemWrite  : request is a load / store
//   Size               : 00 byte, 01 half, 10 word, 11 reserved
//   Unsigned           : loads: 1 zero-extends, 0 sign-extends
//   Address, WriteData : byte address, store data in the low bits
//   ReadMem            : last successful load result
//   Done, Error, Busy  : completion pulse, error flag (with Done), busy
//   mem                : data-memory port (master side)
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  Size,
   input  logic        Unsigned,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadMem,
   output logic        Done,
   output logic        Error,
   output logic        Busy,
   mem_access_unit_if.master mem
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   // Counter must be able to hold TIMEOUT itself.
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   read_mem_q, read_mem_d;
   logic          error_q, error_d;
   logic [1:0]    lane_q, lane_d;
   logic [1:0]    size_q, size_d;
   logic          unsigned_q, unsigned_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   wdata_q, wdata_d;

   logic          illegal_req;
   logic [31:0]   rd_shift;
   logic [31:0]   load_ext;

   assign illegal_req = (MemRead && MemWrite) || (Size == 2'b11) ||
                        (Size == 2'b01 && Address[0]) ||
                        (Size == 2'b10 && Address[1:0] != 2'b00);

   // Half and word accesses are aligned, so a byte-lane shift serves all sizes.
   assign rd_shift = mem.mem_rdata >> {lane_q, 3'b000};

   always_comb begin
      case (size_q)
         2'b00:   load_ext = unsigned_q ? {24'h0, rd_shift[7:0]}
                                        : {{24{rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   load_ext = unsigned_q ? {16'h0, rd_shift[15:0]}
                                        : {{16{rd_shift[15]}}, rd_shift[15:0]};
         default: load_ext = rd_shift;
      endcase
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         read_mem_q <= '0;
         error_q    <= 1'b0;
         lane_q     <= '0;
         size_q     <= '0;
         unsigned_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         read_mem_q <= read_mem_d;
         error_q    <= error_d;
         lane_q     <= lane_d;
         size_q     <= size_d;
         unsigned_q <= unsigned_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
      end
   end

   // Next-state and datapath.
   always_comb begin
      // NOTE: every target gets a default first so no path infers a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      read_mem_d = read_mem_q;
      error_d    = error_q;
      lane_d     = lane_q;
      size_d     = size_q;
      unsigned_d = unsigned_q;
      we_d       = we_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (start && (MemRead || MemWrite)) begin
               if (illegal_req) begin
                  error_d = 1'b1;
                  state_d = S_DONE;
               end else begin
                  error_d    = 1'b0;
                  cnt_d      = '0;
                  lane_d     = Address[1:0];
                  size_d     = Size;
                  unsigned_d = Unsigned;
                  we_d       = MemWrite;
                  addr_d     = {Address[31:2], 2'b00};
                  case (Size)
                     2'b00: begin
                        be_d    = 4'b0001 << Address[1:0];
                        wdata_d = {4{WriteData[7:0]}};
                     end
                     2'b01: begin
                        be_d    = 4'b0011 << {Address[1], 1'b0};
                        wdata_d = {2{WriteData[15:0]}};
                     end
                     default: begin
                        be_d    = 4'b1111;
                        wdata_d = WriteData;
                     end
                  endcase
                  state_d = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            cnt_d = cnt_q + 1'b1;
            if (mem.mem_ready) begin
               if (!we_q) read_mem_d = load_ext;
               error_d = 1'b0;
               state_d = S_DONE;
            end else if (cnt_q == LAST_CNT) begin
               error_d = 1'b1;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs.
   always_comb begin
      Done          = (state_q == S_DONE);
      Busy          = (state_q != S_IDLE);
      Error         = (state_q == S_DONE) && error_q;
      ReadMem       = read_mem_q;
      mem.mem_req   = (state_q == S_ACCESS);
      mem.mem_we    = we_q;
      mem.mem_addr  = addr_q;
      mem.mem_be    = be_q;
      mem.mem_wdata = wdata_q;
   end

endmodule
